// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline hazard controller request/control bundle
interface pipe_hazard_ctrl_if #(
    parameter int N_STAGES = 5,
    parameter int REG_W    = 5
);
    logic [N_STAGES-1:0] stall_req;
    logic [N_STAGES-1:0] flush_req;
    logic [31:0]         redir_pc;
    logic [REG_W-1:0]    d_src0;
    logic [REG_W-1:0]    d_src1;
    logic                d_use0;
    logic                d_use1;
    logic [REG_W-1:0]    e_dst;
    logic                e_is_load;
    logic                md_start;
    logic [N_STAGES-1:0] stall_o;
    logic [N_STAGES-1:0] flush_o;
    logic                pc_redir_vld;
    logic [31:0]         pc_redir;
    logic                md_busy;

    modport master (
        output stall_req, flush_req, redir_pc, d_src0, d_src1, d_use0, d_use1,
               e_dst, e_is_load, md_start,
        input  stall_o, flush_o, pc_redir_vld, pc_redir, md_busy
    );

    modport slave (
        input  stall_req, flush_req, redir_pc, d_src0, d_src1, d_use0, d_use1,
               e_dst, e_is_load, md_start,
        output stall_o, flush_o, pc_redir_vld, pc_redir, md_busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/redirect controller; HAZARD_PERF_CNT_EN adds perf counters
module pipe_hazard_ctrl #(
    parameter int N_STAGES  = 5,
    parameter int REG_W     = 5,
    parameter int MD_CYCLES = 32,
    parameter int E_IDX     = 2
) (
    input  logic        clk,
    input  logic        resetn,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt,
`endif
    pipe_hazard_ctrl_if.slave hz
);
    localparam int CW = $clog2(MD_CYCLES);

    typedef enum logic {IDLE, PEND} state_t;

    state_t              state_q, state_d;
    logic [31:0]         pend_pc_q, pend_pc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                md_busy;
    logic                loaduse;
    logic [N_STAGES-1:0] s;
    logic [N_STAGES-1:0] stall_m;
    logic [N_STAGES-1:0] fmask;
    logic                flush_acc;
    logic [N_STAGES-1:0] stall_v;
    logic [N_STAGES-1:0] flush_v;
    logic                vld;
    logic [31:0]         pc_v;

    assign md_busy = (cnt_q != '0);

    always_comb begin
        loaduse = hz.e_is_load && (hz.e_dst != '0) &&
                  ((hz.d_use0 && (hz.d_src0 == hz.e_dst)) ||
                   (hz.d_use1 && (hz.d_src1 == hz.e_dst)));
        s = hz.stall_req;
        s[1] = s[1] | loaduse;
        s[E_IDX] = s[E_IDX] | md_busy;

        // stall_m[j]: some stall at or above j; fmask[j]: some flush at or above j
        for (int j = 0; j < N_STAGES; j++) begin
            stall_m[j] = |(s >> j);
            fmask[j]   = |(hz.flush_req >> j);
        end

        // A stall strictly older than the oldest flush source blocks the flush
        flush_acc = (|hz.flush_req) && !(|(s & ~fmask));

        stall_v = '0;
        flush_v = '0;
        if (flush_acc) begin
            flush_v = fmask;
            flush_v[0] = 1'b0;
        end else begin
            stall_v = stall_m;
            for (int j = 1; j < N_STAGES; j++)
                flush_v[j] = s[j-1] & ~stall_m[j];
        end

        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        vld       = 1'b0;
        pc_v      = '0;
        if (flush_acc) begin
            if (hz.stall_req[0]) begin
                pend_pc_d = hz.redir_pc;
                state_d   = PEND;
            end else begin
                vld     = 1'b1;
                pc_v    = hz.redir_pc;
                state_d = IDLE;
            end
        end else if (state_q == PEND && !hz.stall_req[0]) begin
            vld     = 1'b1;
            pc_v    = pend_pc_q;
            state_d = IDLE;
        end

        // While a redirect waits, keep the PC and discard whatever fetch produces
        if (state_q == PEND) begin
            flush_v[1] = 1'b1;
            if (!vld)
                stall_v[0] = 1'b1;
        end

        cnt_d = cnt_q;
        if (flush_acc && fmask[E_IDX+1])
            cnt_d = '0;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
        else if (hz.md_start)
            cnt_d = CW'(MD_CYCLES - 1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            pend_pc_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign hz.stall_o      = stall_v;
    assign hz.flush_o      = flush_v;
    assign hz.pc_redir_vld = vld;
    assign hz.pc_redir     = pc_v;
    assign hz.md_busy      = md_busy;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + 32'(stall_v[0]);
        perf_flush_d = perf_flush_q + 32'(flush_acc);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cyc = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed vector bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.N_STAGES(5), .REG_W(5)) hz();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flush_cnt;
`endif

    pipe_hazard_ctrl #(.N_STAGES(5), .REG_W(5), .MD_CYCLES(4), .E_IDX(2)) dut (
        .clk            (clk),
        .resetn         (resetn),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cyc (perf_stall_cyc),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .hz             (hz)
    );

    typedef struct {
        logic [4:0]  stall_req;
        logic [4:0]  flush_req;
        logic [31:0] redir_pc;
        logic [4:0]  d_src0;
        logic [4:0]  d_src1;
        logic        d_use0;
        logic        d_use1;
        logic [4:0]  e_dst;
        logic        e_is_load;
        logic [4:0]  exp_stall;
        logic [4:0]  exp_flush;
        logic        exp_vld;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        hz.stall_req = '0; hz.flush_req = '0; hz.redir_pc = '0;
        hz.d_src0 = '0; hz.d_src1 = '0; hz.d_use0 = 1'b0; hz.d_use1 = 1'b0;
        hz.e_dst = '0; hz.e_is_load = 1'b0; hz.md_start = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic [4:0] st, input logic [4:0] fl,
                           input logic v, input logic [31:0] pc);
        chk({nm, ".stall_o"}, 32'(hz.stall_o), 32'(st));
        chk({nm, ".flush_o"}, 32'(hz.flush_o), 32'(fl));
        chk({nm, ".vld"}, 32'(hz.pc_redir_vld), 32'(v));
        chk({nm, ".pc"}, hz.pc_redir, pc);
    endtask

    initial begin
        //          stall    flush    redir         s0 s1 u0 u1 edst ld   exp_st   exp_fl   v  pc
        vecs[0]  = '{5'b00000, 5'b00000, 32'h0,        0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h0};
        vecs[1]  = '{5'b00000, 5'b00000, 32'h0,        8, 0, 1, 0, 8, 1, 5'b00011, 5'b00100, 0, 32'h0};
        vecs[2]  = '{5'b00000, 5'b00000, 32'h0,        0, 0, 1, 0, 0, 1, 5'b00000, 5'b00000, 0, 32'h0};
        vecs[3]  = '{5'b00000, 5'b00000, 32'h0,        3, 9, 1, 1, 9, 1, 5'b00011, 5'b00100, 0, 32'h0};
        vecs[4]  = '{5'b00000, 5'b00000, 32'h0,        8, 0, 0, 0, 8, 1, 5'b00000, 5'b00000, 0, 32'h0};
        vecs[5]  = '{5'b00000, 5'b00000, 32'h0,        8, 0, 1, 0, 8, 0, 5'b00000, 5'b00000, 0, 32'h0};
        vecs[6]  = '{5'b00100, 5'b00000, 32'h0,        0, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 0, 32'h0};
        vecs[7]  = '{5'b10000, 5'b00000, 32'h0,        0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 0, 32'h0};
        vecs[8]  = '{5'b00001, 5'b00000, 32'h0,        0, 0, 0, 0, 0, 0, 5'b00001, 5'b00010, 0, 32'h0};
        vecs[9]  = '{5'b00000, 5'b01000, 32'hBFC00380, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b01110, 1, 32'hBFC00380};
        vecs[10] = '{5'b01000, 5'b00100, 32'hBFC00380, 0, 0, 0, 0, 0, 0, 5'b01111, 5'b10000, 0, 32'h0};
        vecs[11] = '{5'b00100, 5'b01000, 32'h80000000, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b01110, 1, 32'h80000000};
        vecs[12] = '{5'b00000, 5'b10010, 32'h00001234, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b11110, 1, 32'h00001234};
        vecs[13] = '{5'b00010, 5'b00010, 32'h00005678, 8, 0, 1, 0, 8, 1, 5'b00000, 5'b00010, 1, 32'h00005678};
        vecs[14] = '{5'b10000, 5'b00000, 32'h0,        8, 0, 1, 0, 8, 1, 5'b11111, 5'b00000, 0, 32'h0};

        resetn = 1'b0;
        idle_inputs();
        #1;
        chk_out("reset", 5'b0, 5'b0, 1'b0, 32'h0);
        chk("reset.md_busy", 32'(hz.md_busy), 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            idle_inputs();
            hz.stall_req = vecs[i].stall_req; hz.flush_req = vecs[i].flush_req;
            hz.redir_pc = vecs[i].redir_pc;
            hz.d_src0 = vecs[i].d_src0; hz.d_src1 = vecs[i].d_src1;
            hz.d_use0 = vecs[i].d_use0; hz.d_use1 = vecs[i].d_use1;
            hz.e_dst = vecs[i].e_dst; hz.e_is_load = vecs[i].e_is_load;
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].exp_stall, vecs[i].exp_flush,
                    vecs[i].exp_vld, vecs[i].exp_pc);
            chk($sformatf("vec%0d.md_busy", i), 32'(hz.md_busy), 32'h0);
        end

        // mul/div occupancy
        @(negedge clk); idle_inputs(); hz.md_start = 1'b1; #1;
        chk("md.start_cycle.busy", 32'(hz.md_busy), 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); idle_inputs(); #1;
            chk($sformatf("md.busy%0d", c), 32'(hz.md_busy), 32'h1);
            chk_out($sformatf("md.cyc%0d", c), 5'b00111, 5'b01000, 1'b0, 32'h0);
        end
        @(negedge clk); #1;
        chk("md.done.busy", 32'(hz.md_busy), 32'h0);
        chk_out("md.done", 5'b0, 5'b0, 1'b0, 32'h0);

        // mul/div squashed by a younger-stage flush
        @(negedge clk); hz.md_start = 1'b1;
        @(negedge clk); idle_inputs(); #1;
        chk("sq.busy", 32'(hz.md_busy), 32'h1);
        @(negedge clk); hz.flush_req = 5'b01000; hz.redir_pc = 32'hCAFE0000; #1;
        chk_out("sq.flush", 5'b0, 5'b01110, 1'b1, 32'hCAFE0000);
        @(negedge clk); idle_inputs(); #1;
        chk("sq.cleared", 32'(hz.md_busy), 32'h0);

        // redirect held while fetch is stalled
        @(negedge clk); hz.stall_req = 5'b00001; hz.flush_req = 5'b01000; hz.redir_pc = 32'hBFC00380; #1;
        chk("pend.acc.flush_o", 32'(hz.flush_o), 32'h0E);
        chk("pend.acc.vld", 32'(hz.pc_redir_vld), 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); hz.flush_req = '0; hz.redir_pc = '0; #1;
            chk_out($sformatf("pend.hold%0d", c), 5'b00001, 5'b00010, 1'b0, 32'h0);
        end
        @(negedge clk); hz.stall_req = '0; #1;
        chk_out("pend.release", 5'b00000, 5'b00010, 1'b1, 32'hBFC00380);
        @(negedge clk); #1;
        chk_out("pend.after", 5'b0, 5'b0, 1'b0, 32'h0);

        // newer flush overwrites the pending target
        @(negedge clk); hz.stall_req = 5'b00001; hz.flush_req = 5'b01000; hz.redir_pc = 32'h11110000;
        @(negedge clk); hz.flush_req = 5'b00100; hz.redir_pc = 32'h22220000; #1;
        chk_out("ovw.newer", 5'b00001, 5'b00110, 1'b0, 32'h0);
        @(negedge clk); idle_inputs(); #1;
        chk_out("ovw.release", 5'b00000, 5'b00010, 1'b1, 32'h22220000);

        // asynchronous reset mid-operation
        @(negedge clk); hz.md_start = 1'b1;
        @(negedge clk); idle_inputs(); #1;
        chk("rst.md_busy_before", 32'(hz.md_busy), 32'h1);
        #1 resetn = 1'b0; #1;
        chk("rst.md_busy_after", 32'(hz.md_busy), 32'h0);
        @(negedge clk); resetn = 1'b1;
        hz.stall_req = 5'b00001; hz.flush_req = 5'b01000; hz.redir_pc = 32'h33330000;
        @(negedge clk); idle_inputs(); hz.stall_req = 5'b00001;
        #1 resetn = 1'b0;
        @(negedge clk); resetn = 1'b1; hz.stall_req = '0; #1;
        chk_out("rst.pend_cleared", 5'b0, 5'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
